// File: rtl/bios_loadable_rom.sv
// Field-loadable boot BIOS: DEPTH x WIDTH image, combinational fetch port, sequential valid/ready load port.
// Optional BIOS_CHECKSUM_EN adds a running modular sum of loaded words on load_sum.
module bios_loadable_rom #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 16,
    parameter int unsigned      ADDR_W    = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] JUMP_WORD = 16'b1110_0000_0001_1110
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              load_start,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              load_end,
    output logic              load_busy,
    output logic              load_done,
`ifdef BIOS_CHECKSUM_EN
    output logic [WIDTH-1:0]  load_sum,
`endif
    output logic [ADDR_W:0]   load_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

    state_e             state_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W:0]    count_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               hs;
`ifdef BIOS_CHECKSUM_EN
    logic [WIDTH-1:0]   sum_q;
    assign load_sum = sum_q;
`endif

    assign hs         = load_valid && ready_q;
    assign load_ready = ready_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_count = count_q;

    // Addresses past DEPTH (non-power-of-2 DEPTH) read as zero.
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < DEPTH_W) begin
            rd_data = mem_q[rd_addr];
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == 1) ? JUMP_WORD : '0;
            end
            state_q <= S_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BIOS_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (load_start) begin
                        state_q <= S_LOADING;
                        addr_q  <= '0;
                        count_q <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef BIOS_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                S_LOADING: begin
                    // A restart drops any coincident handshake and overrides load_end.
                    if (load_start) begin
                        addr_q  <= '0;
                        count_q <= '0;
`ifdef BIOS_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end else begin
                        if (hs) begin
                            mem_q[addr_q] <= load_data;
                            count_q       <= count_q + CNT_ONE;
`ifdef BIOS_CHECKSUM_EN
                            sum_q         <= sum_q + load_data;
`endif
                            if (addr_q != LAST_ADDR) begin
                                addr_q <= addr_q + ADDR_ONE;
                            end
                        end
                        if ((hs && addr_q == LAST_ADDR) || load_end) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bios_loadable_rom.sv
// Randomized self-checking bench for bios_loadable_rom against an array/flag reference model.
// Define BIOS_CHECKSUM_EN for both bench and RTL to also check load_sum.
module tb_bios_loadable_rom;

    localparam int W = 16;
    localparam int D = 16;
    localparam int A = 4;

    logic          Clock = 1'b0;
    logic          Reset_n = 1'b0;
    logic [A-1:0]  rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          load_start = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic          load_end = 1'b0;
    logic          load_busy;
    logic          load_done;
    logic [A:0]    load_count;
`ifdef BIOS_CHECKSUM_EN
    logic [W-1:0]  load_sum;
`endif

    bios_loadable_rom #(.WIDTH(W), .DEPTH(D)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .load_start (load_start),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_end   (load_end),
        .load_busy  (load_busy),
        .load_done  (load_done),
`ifdef BIOS_CHECKSUM_EN
        .load_sum   (load_sum),
`endif
        .load_count (load_count)
    );

    always #5 Clock = ~Clock;

    // Reference model: image contents plus "is a load open / did one finish" flags.
    int unsigned ref_mem [D];
    bit          m_loading;
    bit          m_done;
    int unsigned m_next;
    int unsigned m_cnt;
    int unsigned m_sum;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < D; i++) ref_mem[i] = 0;
        ref_mem[1] = 32'hE01E;
        m_loading = 0;
        m_done    = 0;
        m_next    = 0;
        m_cnt     = 0;
        m_sum     = 0;
    endfunction

    function automatic void model_edge(input bit st, input bit vl, input bit en, input int unsigned dt);
        if (!m_loading) begin
            if (st) begin
                m_loading = 1; m_done = 0; m_next = 0; m_cnt = 0; m_sum = 0;
            end
        end else if (st) begin
            m_next = 0; m_cnt = 0; m_sum = 0;
        end else begin
            bool_finish:
            begin
                bit full;
                full = 0;
                if (vl) begin
                    ref_mem[m_next] = dt;
                    m_cnt++;
                    m_sum = (m_sum + dt) % 65536;
                    if (m_next == D - 1) full = 1;
                    else m_next++;
                end
                if (full || en) begin
                    m_loading = 0; m_done = 1;
                end
            end
        end
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".ready"}, load_ready, m_loading);
        check({tag, ".busy"},  load_busy,  m_loading);
        check({tag, ".done"},  load_done,  m_done);
        check({tag, ".count"}, load_count, m_cnt);
`ifdef BIOS_CHECKSUM_EN
        check({tag, ".sum"}, load_sum, m_sum);
`endif
    endtask

    // One clock: inputs already driven; model advances on the same edge as the DUT.
    task automatic cyc(input string tag);
        bit st, vl, en;
        int unsigned dt;
        st = load_start; vl = load_valid; en = load_end; dt = load_data;
        @(posedge Clock);
        #1;
        model_edge(st, vl, en, dt);
        check_status(tag);
    endtask

    task automatic idle_inputs();
        load_start = 0; load_valid = 0; load_end = 0; load_data = '0;
    endtask

    // Only used with idle inputs, so crossing clock edges leaves state unchanged.
    task automatic scan_mem(input string tag);
        for (int i = 0; i < D; i++) begin
            rd_addr = A'(i);
            #1;
            check($sformatf("%s.mem%0d", tag, i), rd_data, ref_mem[i]);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_status("rst");
        Reset_n = 1;
        @(posedge Clock); #1;
        check_status("post_rst");
        scan_mem("boot");

        // load_end outside a load is ignored
        load_end = 1;
        cyc("end_idle");
        idle_inputs();

        // Full 16-word load
        load_start = 1;
        cyc("full_start");
        load_start = 0;
        for (int i = 0; i < D; i++) begin
            load_valid = 1; load_data = W'(16'h1000 + i);
            cyc($sformatf("full_w%0d", i));
        end
        idle_inputs();
        check("full.done", load_done, 1);
        check("full.count", load_count, 16);
        rd_addr = 4'd5; #1;
        check("full.rd5", rd_data, 16'h1005);
        // load_valid in DONE ignored
        load_valid = 1; load_data = 16'hDEAD;
        cyc("done_ignore");
        idle_inputs();
        scan_mem("full");

        // Partial load, load_end with third word
        load_start = 1;
        cyc("part_start");
        load_start = 0; load_valid = 1;
        load_data = 16'hAAAA; cyc("part_w0");
        load_data = 16'hBBBB; cyc("part_w1");
        load_data = 16'hCCCC; load_end = 1; cyc("part_w2");
        idle_inputs();
        check("part.count", load_count, 3);
        rd_addr = 4'd2; #1; check("part.rd2", rd_data, 16'hCCCC);
        rd_addr = 4'd1; #1; check("part.rd1", rd_data, 16'hBBBB);
        rd_addr = 4'd3; #1; check("part.rd3", rd_data, 16'h1003);

        // Start and end together: start wins
        load_start = 1; load_end = 1;
        cyc("st_end_idle");
        cyc("st_end_loading");
        idle_inputs();
        load_end = 1; cyc("close");
        idle_inputs();

        // Randomized traffic including stalls, restarts, end pulses; same-cycle reads see the old word
        for (int n = 0; n < 600; n++) begin
            load_start = ($urandom_range(0, 19) == 0);
            load_end   = ($urandom_range(0, 24) == 0);
            load_valid = (n % 2 == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
            load_data  = W'($urandom);
            rd_addr    = m_loading ? A'(m_next) : A'($urandom_range(0, D - 1));
            #1;
            check("rnd.rd_old", rd_data, ref_mem[rd_addr]);
            cyc("rnd");
            #1;
        end
        idle_inputs();
        scan_mem("rnd");

        // Reset mid-load after 5 words discards the partial image
        load_start = 1; cyc("rl_start");
        load_start = 0; load_valid = 1;
        for (int i = 0; i < 5; i++) begin
            load_data = W'(16'h5A00 + i);
            cyc("rl_w");
        end
        idle_inputs();
        #2;
        Reset_n = 0;
        model_reset();
        #1;
        check_status("midrst");
        rd_addr = 4'd1; #1; check("midrst.rd1", rd_data, 16'hE01E);
        rd_addr = 4'd0; #1; check("midrst.rd0", rd_data, 16'h0000);
        @(negedge Clock);
        Reset_n = 1;
        scan_mem("midrst");

`ifdef BIOS_CHECKSUM_EN
        load_start = 1; cyc("cs_start");
        load_start = 0;
        for (int i = 1; i <= D; i++) begin
            load_valid = 1; load_data = W'(i);
            cyc("cs_w");
        end
        idle_inputs();
        check("cs.sum", load_sum, 16'h0088);
        load_start = 1; cyc("cs_clear");
        idle_inputs();
        check("cs.cleared", load_sum, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
